// File: rtl/weight_load_sequencer.sv
// rtl/weight_load_sequencer.sv - descriptor-driven sequencer that streams weight segments from external memory into the weight loader
module weight_load_sequencer #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 32,
   parameter int NUM_SEGMENTS    = 16,
   parameter int LEN_WIDTH       = 24,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cfg_we,
   input  logic [$clog2(NUM_SEGMENTS)-1:0]   cfg_idx,
   input  logic [ADDR_WIDTH-1:0]             cfg_src_addr,
   input  logic [ADDR_WIDTH-1:0]             cfg_dst_addr,
   input  logic [LEN_WIDTH-1:0]              cfg_len,
   input  logic [$clog2(NUM_SEGMENTS+1)-1:0] cfg_num_segments,
   input  logic                              start,
   input  logic                              abort,
   output logic                              mem_rd_req,
   output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
   input  logic                              mem_rd_gnt,
   input  logic                              mem_rd_valid,
   input  logic [DATA_WIDTH-1:0]             mem_rd_data,
   input  logic                              mem_rd_err,
   output logic [ADDR_WIDTH-1:0]             weight_addr,
   output logic [DATA_WIDTH-1:0]             weight_data,
   output logic                              weight_write_en,
   output logic                              weight_load_start,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   output logic [1:0]                        error_code,
   output logic [$clog2(NUM_SEGMENTS)-1:0]   cur_segment,
   output logic [31:0]                       words_written
);

   localparam int IW = $clog2(NUM_SEGMENTS);
   localparam int SW = $clog2(NUM_SEGMENTS + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_DESC,
      S_RUN,
      S_DRAIN,
      S_DRAIN_FINAL,
      S_DONE,
      S_ERROR
   } state_t;

   state_t state_q, state_d;

   // Descriptor table; deliberately survives reset so a reboot can re-run it.
   logic [ADDR_WIDTH-1:0] tbl_src [NUM_SEGMENTS];
   logic [ADDR_WIDTH-1:0] tbl_dst [NUM_SEGMENTS];
   logic [LEN_WIDTH-1:0]  tbl_len [NUM_SEGMENTS];

   logic [SW-1:0]         seg;
   logic [SW-1:0]         num_seg;
   logic [ADDR_WIDTH-1:0] src_base;
   logic [ADDR_WIDTH-1:0] dst_base;
   logic [LEN_WIDTH-1:0]  seg_len;
   logic [LEN_WIDTH-1:0]  issued;
   logic [LEN_WIDTH-1:0]  received;
   logic [OW-1:0]         outstanding;
   logic [WW-1:0]         wd_count;
   logic [1:0]            pend_code;

   logic [IW-1:0] idx;
   logic          rd_hs;
   logic          rsp;
   logic          rsp_ok;
   logic          rsp_bad;
   logic          timeout;
   logic          idle_like;

   assign idx         = seg[IW-1:0];
   assign cur_segment = seg[IW-1:0];
   assign rd_hs       = mem_rd_req & mem_rd_gnt;
   // A response with nothing outstanding is stray and never counts.
   assign rsp         = mem_rd_valid && (outstanding != '0);
   assign rsp_ok      = rsp && !mem_rd_err;
   assign rsp_bad     = rsp && mem_rd_err;
   assign timeout     = (outstanding != '0) && !mem_rd_valid && (wd_count == WW'(TIMEOUT_CYCLES - 1));
   assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
   assign busy        = !idle_like;
   assign done        = (state_q == S_DONE);
   assign error       = (state_q == S_ERROR);
   assign mem_rd_addr = src_base + ADDR_WIDTH'(issued);

   // Descriptor writes are only accepted while no sequence owns the table.
   always_ff @(posedge clk) begin
      if (cfg_we && idle_like) begin
         tbl_src[cfg_idx] <= cfg_src_addr;
         tbl_dst[cfg_idx] <= cfg_dst_addr;
         tbl_len[cfg_idx] <= cfg_len;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state and read-request decode; error causes ranked err > timeout > abort.
   always_comb begin
      state_d    = state_q;
      mem_rd_req = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_d = S_LOAD_DESC;
         end
         S_LOAD_DESC: begin
            if (abort)                       state_d = S_DRAIN;
            else if (seg == num_seg)         state_d = S_DRAIN_FINAL;
            else if (tbl_len[idx] != '0)     state_d = S_RUN;
         end
         S_RUN: begin
            mem_rd_req = (issued < seg_len) && (outstanding < OW'(MAX_OUTSTANDING)) && !abort;
            if (rsp_bad)                     state_d = S_DRAIN;
            else if (timeout)                state_d = S_ERROR;
            else if (abort)                  state_d = S_DRAIN;
            else if (received == seg_len)    state_d = S_LOAD_DESC;
         end
         S_DRAIN: begin
            if (timeout || (outstanding == '0)) state_d = S_ERROR;
         end
         S_DRAIN_FINAL: begin
            if (abort) state_d = S_DRAIN;
            else       state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: segment walking, read accounting, loader writes and status.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg               <= '0;
         num_seg           <= '0;
         src_base          <= '0;
         dst_base          <= '0;
         seg_len           <= '0;
         issued            <= '0;
         received          <= '0;
         outstanding       <= '0;
         wd_count          <= '0;
         pend_code         <= 2'd0;
         error_code        <= 2'd0;
         words_written     <= '0;
         weight_addr       <= '0;
         weight_data       <= '0;
         weight_write_en   <= 1'b0;
         weight_load_start <= 1'b0;
      end else begin
         weight_write_en   <= 1'b0;
         weight_load_start <= 1'b0;

         if (timeout) outstanding <= '0;
         else         outstanding <= outstanding + OW'(rd_hs) - OW'(rsp);

         if ((outstanding != '0) && !mem_rd_valid && !timeout) wd_count <= wd_count + 1'b1;
         else                                                  wd_count <= '0;

         if (rd_hs) issued <= issued + 1'b1;

         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  num_seg           <= cfg_num_segments;
                  seg               <= '0;
                  words_written     <= '0;
                  error_code        <= 2'd0;
                  pend_code         <= 2'd0;
                  weight_load_start <= 1'b1;
               end
            end
            S_LOAD_DESC: begin
               if (abort) begin
                  pend_code <= 2'd3;
               end else if (seg != num_seg) begin
                  if (tbl_len[idx] == '0) begin
                     seg <= seg + 1'b1;
                  end else begin
                     src_base <= tbl_src[idx];
                     dst_base <= tbl_dst[idx];
                     seg_len  <= tbl_len[idx];
                     issued   <= '0;
                     received <= '0;
                  end
               end
            end
            S_RUN: begin
               if (rsp_bad)                  pend_code <= 2'd1;
               else if (timeout)             pend_code <= 2'd2;
               else if (abort)               pend_code <= 2'd3;
               else if (received == seg_len) seg       <= seg + 1'b1;
               if (rsp_ok && !abort) begin
                  weight_write_en <= 1'b1;
                  weight_addr     <= dst_base + ADDR_WIDTH'(received);
                  weight_data     <= mem_rd_data;
                  received        <= received + 1'b1;
                  words_written   <= words_written + 32'd1;
               end
            end
            S_DRAIN_FINAL: begin
               if (abort) pend_code <= 2'd3;
            end
            default: ;
         endcase

         // A timeout in RUN is its own cause; from DRAIN the earlier cause stands.
         if ((state_d == S_ERROR) && (state_q != S_ERROR))
            error_code <= (state_q == S_RUN) ? 2'd2 : pend_code;
      end
   end

endmodule

// File: doc/weight_load_sequencer.md
Name: weight_load_sequencer

Overview:
Programmable DMA-style sequencer that fills the weight store of the MobileNetV3-Small accelerator.
- Walks a descriptor table of weight segments (conv1, blocks 0-10 expand/dw/pw/SE/shortcut, conv2, linear3, linear4 and the fused BN scale/bias sets).
- Fetches bytes from external memory over a request/grant/response interface.
- Drives the weight loader's memory-mapped write port (weight_addr/weight_data/weight_write_en).
- Sits between the host/boot controller and the weight loader; it owns that write port exclusively while busy.

Parameters:
- DATA_WIDTH, 8: weight byte width.
- ADDR_WIDTH, 32: source and destination address width.
- NUM_SEGMENTS, 16: descriptor table depth.
- LEN_WIDTH, 24: segment length field width, in words.
- MAX_OUTSTANDING, 4: maximum granted reads awaiting response.
- TIMEOUT_CYCLES, 1024: response watchdog limit.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- cfg_we  in  1  write one descriptor
- cfg_idx  in  $clog2(NUM_SEGMENTS)  descriptor index
- cfg_src_addr  in  ADDR_WIDTH  external memory base
- cfg_dst_addr  in  ADDR_WIDTH  weight-loader base address
- cfg_len  in  LEN_WIDTH  words in segment
- cfg_num_segments  in  $clog2(NUM_SEGMENTS+1)  segments to run, sampled at start
- start  in  1  begin sequence
- abort  in  1  stop sequence
- mem_rd_req  out  1  read request
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_gnt  in  1  request accepted this cycle
- mem_rd_valid  in  1  response valid, in order
- mem_rd_data  in  DATA_WIDTH  response data
- mem_rd_err  in  1  response error, qualified by valid
- weight_addr  out  ADDR_WIDTH  loader write address
- weight_data  out  DATA_WIDTH  loader write data
- weight_write_en  out  1  loader write strobe
- weight_load_start  out  1  one-cycle pulse to loader at sequence start
- busy  out  1  sequence active
- done  out  1  sticky successful completion
- error  out  1  sticky failure
- error_code  out  2  0 none, 1 mem_rd_err, 2 timeout, 3 abort
- cur_segment  out  $clog2(NUM_SEGMENTS)  active descriptor
- words_written  out  32  total loader writes this sequence

Behaviour:
Reset (rst=0 at a clk edge):
- All outputs 0; state IDLE; outstanding and watchdog counters 0.
- Descriptor table is not cleared.
- Reset mid-sequence aborts immediately; no further writes.

Descriptor writes:
- cfg_we writes table[cfg_idx] in IDLE, DONE or ERROR.
- cfg_we is ignored while busy.

IDLE:
- start=1 -> LOAD_DESC. In the same transition: latch cfg_num_segments, clear done/error/error_code/words_written, pulse weight_load_start, busy=1, cur_segment=0.
- start while busy is ignored.

LOAD_DESC (1 cycle):
- If cur_segment == num_segments -> DRAIN_FINAL.
- Else if table[cur_segment].len == 0 -> increment cur_segment, stay in LOAD_DESC.
- Else load issue pointer, response pointer, dst base and count -> RUN.

RUN:
- mem_rd_req=1 while issued < len, outstanding < MAX_OUTSTANDING and no abort.
- mem_rd_addr = src + issued.
- Request handshake completes on req & gnt; issued increments.
- req and addr hold stable until granted.
- Response handling on mem_rd_valid:
  - Valid with err=0: registered write next cycle, so weight_write_en=1 exactly one cycle, weight_addr = dst + received, weight_data = mem_rd_data.
  - words_written increments on each write.
- Grant and response in the same cycle: outstanding is unchanged.
- When received == len -> increment cur_segment -> LOAD_DESC.
- First mem_rd_req is asserted 2 cycles after start is sampled.
- A new segment's reads may not issue until the previous segment's responses have all arrived.

DRAIN_FINAL:
- One cycle to retire the last write -> DONE.
- DONE: done=1, busy=0; start allowed.

Errors (all go to ERROR: error=1, busy=0, code sticky until next start):
- mem_rd_valid & mem_rd_err: no write for that word; stop issuing; discard remaining responses until outstanding==0 -> ERROR, code 1.
- Watchdog: counts cycles with outstanding>0 and no valid; reaching TIMEOUT_CYCLES -> ERROR, code 2; outstanding forced to 0.
- abort while busy: stop issuing; drain outstanding responses without writing; then ERROR, code 3.
- abort in IDLE, DONE or ERROR has no effect.
- Error precedence in the same cycle: mem_rd_err > timeout > abort.
- mem_rd_valid with outstanding==0 is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Single segment: src=0x1000, dst=0x200, len=4, gnt tied 1, 2-cycle response latency, data 0x11..0x14 -> writes to 0x200..0x203 with data 0x11..0x14, words_written=4, done=1, error_code=0.
- Back-pressure: len=10, gnt=1, responses withheld -> exactly 4 grants then mem_rd_req low; releasing one response -> exactly one more request.
- Three segments with lengths 3, 0, 2 (num=3) -> 5 writes, segment 1 skipped, cur_segment reaches 3, done. num_segments=0 -> done with zero writes and no mem_rd_req.
- mem_rd_err on word 2 of len=6 -> 2 writes only, error=1, error_code=1, busy falls after outstanding drains.
- TIMEOUT_CYCLES=16 and no response after grant -> error_code=2 at cycle 16 of waiting. abort mid-segment -> no writes after drain, error_code=3. start during busy -> no effect.
- rst=0 mid-RUN -> next cycle all outputs 0; new start re-runs cleanly with the retained descriptors.
